// File: rtl/packed_array_serializer_if.sv
// ---------------------------------------------------------------------------
// packed_array_serializer_if
//
// Bundles the two streams of the packed-array serializer:
//   - wide input stream : in_data / in_valid / in_ready
//   - narrow output stream: out_data / out_index / out_last / out_valid / out_ready
//
// Modports:
//   slave  - the serializer itself (consumes the wide word, produces elements)
//   master - the environment around it (produces words, consumes elements)
//
// Parameters must match those given to the serializer instance.
// ---------------------------------------------------------------------------
interface packed_array_serializer_if #(
  parameter int unsigned ELEM_W   = 2,
  parameter int unsigned NUM_ELEM = 4
);

  localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  logic [NUM_ELEM*ELEM_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [ELEM_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [IDX_W-1:0]           out_index;
  logic                       out_last;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_index,
    output out_last
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_index,
    input  out_last
  );

endinterface

// File: rtl/packed_array_serializer.sv
// ---------------------------------------------------------------------------
// packed_array_serializer
//
// Accepts one packed array word of NUM_ELEM elements (ELEM_W bits each)
// through a valid/ready handshake and emits its elements one per cycle on a
// narrow valid/ready stream, together with the element index and a last flag.
// A new word may be accepted on the same cycle the last element of the
// current one is consumed, so a continuous supply streams without bubbles.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - synchronous, active-high reset
//   bus.in_data    - packed word; element k at bits [k*ELEM_W +: ELEM_W]
//   bus.in_valid   - in_data is valid
//   bus.in_ready   - word accepted this cycle (combinational on out_ready/rst)
//   bus.out_data   - current element
//   bus.out_valid  - out_data/out_index/out_last are valid
//   bus.out_ready  - downstream takes the current element
//   bus.out_index  - array index of the current element
//   bus.out_last   - current element is the final one of the word
//
// Parameters:
//   ELEM_W    - element width in bits (>= 1)
//   NUM_ELEM  - elements per word (>= 1)
//   MSB_FIRST - 1: element NUM_ELEM-1 first, 0: element 0 first
// ---------------------------------------------------------------------------
module packed_array_serializer #(
  parameter int unsigned ELEM_W    = 2,
  parameter int unsigned NUM_ELEM  = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  packed_array_serializer_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  // Index of the first and of the final element emitted for a word.
  localparam logic [IDX_W-1:0] FirstIdx = MSB_FIRST ? IDX_W'(NUM_ELEM - 1) : '0;
  localparam logic [IDX_W-1:0] LastIdx  = MSB_FIRST ? '0 : IDX_W'(NUM_ELEM - 1);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_ELEM-1:0][ELEM_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]                cnt_q, cnt_d;

  logic send_st;
  logic is_last;
  logic in_fire;
  logic out_fire;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          state_d = StSend;
        end
      end
      StSend: begin
        // A word accepted alongside the last element keeps us in StSend.
        if (out_fire && is_last && !in_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode and handshake qualifiers
  // -------------------------------------------------------------------------
  always_comb begin
    send_st       = (state_q == StSend);
    is_last       = send_st && (cnt_q == LastIdx);
    bus.out_valid = send_st;
    // Decode is gated by StSend so an idle block presents all-zero outputs,
    // whatever value the counter was left at.
    bus.out_data  = send_st ? shadow_q[cnt_q] : '0;
    bus.out_index = send_st ? cnt_q : '0;
    bus.out_last  = is_last;
    out_fire      = send_st && bus.out_ready;
    bus.in_ready  = !rst && (!send_st || (out_fire && is_last));
    in_fire       = bus.in_valid && bus.in_ready;
  end

  // -------------------------------------------------------------------------
  // Shadow word and element counter
  // -------------------------------------------------------------------------
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (in_fire) begin
      shadow_d = bus.in_data;
      cnt_d    = FirstIdx;
    end else if (out_fire && !is_last) begin
      // The last element never advances, so the counter cannot wrap.
      cnt_d = MSB_FIRST ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  // A stalled element must not change under the consumer.
  stall_stable_a : assert property (@(posedge clk)
    !rst && bus.out_valid && !bus.out_ready |=>
      $stable(bus.out_data) && $stable(bus.out_index) && $stable(bus.out_last));

  cnt_in_range_a : assert property (@(posedge clk) 32'(cnt_q) < NUM_ELEM);

  no_accept_mid_word_a : assert property (@(posedge clk)
    bus.out_valid && !bus.out_last |-> !bus.in_ready);

endmodule

// File: tb/tb_packed_array_serializer.sv
// ---------------------------------------------------------------------------
// tb_packed_array_serializer
//
// Three serializer builds share clock and reset:
//   inst 0 : ELEM_W=2, NUM_ELEM=4, MSB_FIRST=1
//   inst 1 : ELEM_W=2, NUM_ELEM=4, MSB_FIRST=0
//   inst 2 : ELEM_W=2, NUM_ELEM=1
// Each accepted word is expanded by a reference model into the list of
// elements it must produce; a per-cycle monitor compares the DUT outputs with
// the head of that list and pops on every output transfer.
// ---------------------------------------------------------------------------
module tb_packed_array_serializer;

  typedef struct {
    int data;
    int index;
    bit last;
  } elem_t;

  logic clk = 1'b0;
  logic rst;
  bit   armed = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  elem_t q_msb[$];
  elem_t q_lsb[$];
  elem_t q_one[$];

  always #5 clk = ~clk;

  packed_array_serializer_if #(.ELEM_W(2), .NUM_ELEM(4)) bm ();
  packed_array_serializer_if #(.ELEM_W(2), .NUM_ELEM(4)) bl ();
  packed_array_serializer_if #(.ELEM_W(2), .NUM_ELEM(1)) bo ();

  packed_array_serializer #(.ELEM_W(2), .NUM_ELEM(4), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  packed_array_serializer #(.ELEM_W(2), .NUM_ELEM(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bl)
  );

  packed_array_serializer #(.ELEM_W(2), .NUM_ELEM(1), .MSB_FIRST(1'b1)) u_one (
    .clk (clk),
    .rst (rst),
    .bus (bo)
  );

  // ---------------------------------------------------------------- helpers
  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) begin
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endfunction

  function automatic int q_size(input int inst);
    case (inst)
      0:       return q_msb.size();
      1:       return q_lsb.size();
      default: return q_one.size();
    endcase
  endfunction

  function automatic elem_t q_head(input int inst);
    case (inst)
      0:       return q_msb[0];
      1:       return q_lsb[0];
      default: return q_one[0];
    endcase
  endfunction

  function automatic void q_pop(input int inst);
    case (inst)
      0:       void'(q_msb.pop_front());
      1:       void'(q_lsb.pop_front());
      default: void'(q_one.pop_front());
    endcase
  endfunction

  function automatic void q_clear(input int inst);
    case (inst)
      0:       q_msb.delete();
      1:       q_lsb.delete();
      default: q_one.delete();
    endcase
  endfunction

  // Reference model: the element sequence a word must turn into.
  function automatic void push_word(input int inst, input logic [7:0] word, input int n,
                                    input bit msb);
    elem_t e;
    int    idx;
    for (int k = 0; k < n; k++) begin
      idx     = msb ? (n - 1 - k) : k;
      e.data  = int'((word >> (idx * 2)) & 8'h03);
      e.index = idx;
      e.last  = (k == n - 1);
      case (inst)
        0:       q_msb.push_back(e);
        1:       q_lsb.push_back(e);
        default: q_one.push_back(e);
      endcase
    end
  endfunction

  // One monitor step for one instance, evaluated mid-cycle.
  function automatic void mon(input int inst, input string tag, input bit rst_v, input bit iv,
                              input bit ir, input bit ov, input bit ordy, input int od,
                              input int oi, input bit ol, input logic [7:0] word,
                              input int n, input bit msb);
    int    sz;
    bit    exp_ir;
    elem_t h;
    sz     = q_size(inst);
    exp_ir = !rst_v && (sz == 0 || (sz == 1 && ordy));
    check({tag, ".out_valid"}, int'(ov), int'(sz > 0));
    check({tag, ".in_ready"}, int'(ir), int'(exp_ir));
    if (sz > 0) begin
      h = q_head(inst);
      check({tag, ".out_data"}, od, h.data);
      check({tag, ".out_index"}, oi, h.index);
      check({tag, ".out_last"}, int'(ol), int'(h.last));
    end else begin
      check({tag, ".idle_data"}, od, 0);
      check({tag, ".idle_index"}, oi, 0);
      check({tag, ".idle_last"}, int'(ol), 0);
    end
    if (rst_v) begin
      q_clear(inst);
    end else begin
      if (sz > 0 && ordy) q_pop(inst);
      if (iv && exp_ir) push_word(inst, word, n, msb);
    end
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      mon(0, "msb", rst, bm.in_valid, bm.in_ready, bm.out_valid, bm.out_ready,
          int'(bm.out_data), int'(bm.out_index), bm.out_last, bm.in_data, 4, 1'b1);
      mon(1, "lsb", rst, bl.in_valid, bl.in_ready, bl.out_valid, bl.out_ready,
          int'(bl.out_data), int'(bl.out_index), bl.out_last, bl.in_data, 4, 1'b0);
      mon(2, "one", rst, bo.in_valid, bo.in_ready, bo.out_valid, bo.out_ready,
          int'(bo.out_data), int'(bo.out_index), bo.out_last, {6'd0, bo.in_data}, 1, 1'b1);
    end
  end

  // --------------------------------------------------------------- drivers
  function automatic void set_in(input int inst, input bit v, input logic [7:0] w);
    case (inst)
      0:       begin bm.in_valid = v; bm.in_data = w; end
      1:       begin bl.in_valid = v; bl.in_data = w; end
      default: begin bo.in_valid = v; bo.in_data = w[1:0]; end
    endcase
  endfunction

  function automatic void set_ordy(input int inst, input bit r);
    case (inst)
      0:       bm.out_ready = r;
      1:       bl.out_ready = r;
      default: bo.out_ready = r;
    endcase
  endfunction

  function automatic bit get_ir(input int inst);
    case (inst)
      0:       return bm.in_ready;
      1:       return bl.in_ready;
      default: return bo.in_ready;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until accepted, bounded to 50 cycles.
  task automatic send(input int inst, input logic [7:0] word);
    int guard = 0;
    set_in(inst, 1'b1, word);
    do begin
      @(negedge clk);
      guard++;
    end while (!get_ir(inst) && guard < 50);
    if (!get_ir(inst)) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst %0d: in_ready got 0 expected 1 within 50 cycles", inst);
    end
    tick();
    set_in(inst, 1'b0, word);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    set_in(0, 1'b1, 8'hFF);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) set_ordy(i, 1'b1);

    // Reset held two cycles while a word is offered; it must be ignored.
    tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;
    set_in(0, 1'b0, 8'hFF);
    tick();

    // Basic MSB-first and LSB-first.
    send(0, 8'b11_10_01_00);
    repeat (5) tick();
    send(1, 8'b11_10_01_00);
    repeat (5) tick();

    // Backpressure: stall three cycles on the second element.
    send(0, 8'hE4);
    tick();
    set_ordy(0, 1'b0);
    repeat (3) tick();
    set_ordy(0, 1'b1);
    repeat (5) tick();

    // Back-to-back words with in_valid held high.
    send(0, 8'hE4);
    send(0, 8'h1B);
    repeat (6) tick();

    // Reset after two elements of a word.
    send(0, 8'hE4);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Single-element build.
    send(2, 8'h02);
    send(2, 8'h01);
    repeat (3) tick();

    // Randomized traffic on both four-element builds.
    done_cnt = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(0, 8'($urandom));
        end
        done_cnt++;
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(1, 8'($urandom));
        end
        done_cnt++;
      end
      begin
        while (done_cnt < 2) begin
          set_ordy(0, $urandom_range(0, 3) != 0);
          set_ordy(1, $urandom_range(0, 3) != 0);
          tick();
        end
      end
    join

    // Drain and confirm every expected element was produced.
    for (int i = 0; i < 3; i++) set_ordy(i, 1'b1);
    repeat (8) tick();
    check("msb_drained", q_msb.size(), 0);
    check("lsb_drained", q_lsb.size(), 0);
    check("one_drained", q_one.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
